// File: rtl/commit_scheduler.sv
// In-order commit scheduler: holds speculative offloaded instructions until committed or killed,
// then dispatches committed ones in issue order; head waits on dispatch_ready, killed heads drop silently.
module commit_scheduler #(
  parameter int X_ID_WIDTH  = 4,
  parameter int QUEUE_DEPTH = 4,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                           ck,
  input  logic                           rst,
  input  logic                           issue_valid,
  output logic                           issue_ready,
  input  logic [X_ID_WIDTH-1:0]          issue_id,
  input  logic [INSTR_WIDTH-1:0]         issue_instr,
  input  logic                           commit_valid,
  input  logic [X_ID_WIDTH-1:0]          commit_id,
  input  logic                           commit_kill,
  output logic                           dispatch_valid,
  input  logic                           dispatch_ready,
  output logic [X_ID_WIDTH-1:0]          dispatch_id,
  output logic [INSTR_WIDTH-1:0]         dispatch_instr,
  output logic [$clog2(QUEUE_DEPTH):0]   occupancy,
  output logic                           commit_miss
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic                   valid;
    logic                   committed;
    logic                   killed;
    logic [X_ID_WIDTH-1:0]  id;
    logic [INSTR_WIDTH-1:0] instr;
  } entry_t;

  entry_t          q [QUEUE_DEPTH];
  entry_t          head_e;
  logic [PW-1:0]   head, tail, idx, match_idx;
  logic            match_found, issue_acc, new_match, retire;

  // Walk from head towards tail so the oldest pending entry with this ID wins.
  always_comb begin
    match_found = 1'b0;
    match_idx   = head;
    idx         = head;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      idx = head + PW'(i);
      if (!match_found && q[idx].valid && !q[idx].committed && !q[idx].killed &&
          q[idx].id == commit_id) begin
        match_found = 1'b1;
        match_idx   = idx;
      end
    end
  end

  always_comb begin
    head_e         = q[head];
    issue_ready    = rst & (occupancy != CW'(QUEUE_DEPTH));
    issue_acc      = issue_valid & issue_ready;
    dispatch_valid = head_e.valid & head_e.committed & ~head_e.killed;
    dispatch_id    = head_e.id;
    dispatch_instr = head_e.instr;
    retire         = (dispatch_valid & dispatch_ready) | (head_e.valid & head_e.killed);
    // A same-cycle issue is the youngest entry, so it only catches commits nothing older claimed.
    new_match      = commit_valid & issue_acc & ~match_found & (issue_id == commit_id);
  end

  always_ff @(posedge ck) begin
    if (!rst) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) q[i] <= '0;
      head        <= '0;
      tail        <= '0;
      occupancy   <= '0;
      commit_miss <= 1'b0;
    end else begin
      if (retire) begin
        q[head].valid <= 1'b0;
        head          <= head + PW'(1);
      end
      if (issue_acc) begin
        q[tail] <= '{valid:     1'b1,
                     committed: new_match & ~commit_kill,
                     killed:    new_match & commit_kill,
                     id:        issue_id,
                     instr:     issue_instr};
        tail    <= tail + PW'(1);
      end
      if (commit_valid && match_found) begin
        if (commit_kill) q[match_idx].killed    <= 1'b1;
        else             q[match_idx].committed <= 1'b1;
      end
      case ({issue_acc, retire})
        2'b10:   occupancy <= occupancy + CW'(1);
        2'b01:   occupancy <= occupancy - CW'(1);
        default: occupancy <= occupancy;
      endcase
      commit_miss <= commit_valid & ~match_found & ~new_match;
    end
  end

endmodule

// File: tb/tb_commit_scheduler.sv
// Bench for commit_scheduler: directed vector table, hand sequences, then random traffic vs a queue model.
module tb_commit_scheduler;

  logic        ck = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic [3:0]  issue_id;
  logic [31:0] issue_instr;
  logic        commit_valid;
  logic [3:0]  commit_id;
  logic        commit_kill;
  logic        dispatch_valid;
  logic        dispatch_ready;
  logic [3:0]  dispatch_id;
  logic [31:0] dispatch_instr;
  logic [2:0]  occupancy;
  logic        commit_miss;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 ck = ~ck;

  commit_scheduler #(.X_ID_WIDTH(4), .QUEUE_DEPTH(4), .INSTR_WIDTH(32)) dut (
    .ck(ck), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_id(issue_id), .issue_instr(issue_instr),
    .commit_valid(commit_valid), .commit_id(commit_id), .commit_kill(commit_kill),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_id(dispatch_id), .dispatch_instr(dispatch_instr),
    .occupancy(occupancy), .commit_miss(commit_miss)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: age-ordered queue; st 0 = pending, 1 = committed, 2 = killed.
  typedef struct { logic [3:0] id; logic [31:0] instr; int st; } ment_t;
  ment_t mq[$];
  bit    m_miss;

  task automatic check_model();
    bit exp_dv;
    exp_dv = (mq.size() > 0) && (mq[0].st == 1);
    chk("m_issue_ready", issue_ready, rst && (mq.size() < 4));
    chk("m_dispatch_valid", dispatch_valid, exp_dv);
    chk("m_occupancy", occupancy, mq.size());
    chk("m_commit_miss", commit_miss, m_miss);
    if (exp_dv) begin
      chk("m_dispatch_id", dispatch_id, mq[0].id);
      chk("m_dispatch_instr", dispatch_instr, mq[0].instr);
    end
  endtask

  task automatic model_update();
    bit done, acc;
    int hit;
    if (!rst) begin
      mq.delete();
      m_miss = 0;
      return;
    end
    done = (mq.size() > 0) && ((mq[0].st == 2) || (mq[0].st == 1 && dispatch_ready));
    acc  = issue_valid && (mq.size() < 4);
    hit  = -1;
    for (int i = 0; i < mq.size(); i++)
      if (hit < 0 && mq[i].st == 0 && mq[i].id == commit_id) hit = i;
    if (acc) mq.push_back('{id: issue_id, instr: issue_instr, st: 0});
    m_miss = 0;
    if (commit_valid) begin
      if (hit >= 0) mq[hit].st = commit_kill ? 2 : 1;
      else if (acc && issue_id == commit_id) mq[mq.size()-1].st = commit_kill ? 2 : 1;
      else m_miss = 1;
    end
    if (done) void'(mq.pop_front());
  endtask

  task automatic cyc();
    #1;
    check_model();
    @(posedge ck);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid  = 0; issue_id = 0; issue_instr = 0;
    commit_valid = 0; commit_id = 0; commit_kill = 0;
  endtask

  typedef struct {
    bit r, iv; logic [3:0] iid; bit cv; logic [3:0] cid; bit kl;
    bit e_ir, e_dv; logic [3:0] e_did; int e_occ; bit e_miss;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit r, iv, input logic [3:0] iid, input bit cv, input logic [3:0] cid,
                     input bit kl, e_ir, e_dv, input logic [3:0] e_did, input int e_occ, input bit e_miss);
    tbl.push_back('{r: r, iv: iv, iid: iid, cv: cv, cid: cid, kl: kl,
                    e_ir: e_ir, e_dv: e_dv, e_did: e_did, e_occ: e_occ, e_miss: e_miss});
  endtask

  initial begin
    // Each row: inputs for one cycle, expected outputs seen during that cycle.
    add(0,0,0, 0,0,0, 0,0,0, 0,0);
    add(1,1,1, 0,0,0, 1,0,0, 0,0);
    add(1,1,2, 0,0,0, 1,0,0, 1,0);
    add(1,1,3, 0,0,0, 1,0,0, 2,0);
    add(1,0,0, 1,1,0, 1,0,0, 3,0);
    add(1,0,0, 1,2,0, 1,1,1, 3,0);
    add(1,0,0, 1,3,0, 1,1,2, 2,0);
    add(1,0,0, 0,0,0, 1,1,3, 1,0);
    add(1,0,0, 0,0,0, 1,0,0, 0,0);
    add(1,1,1, 0,0,0, 1,0,0, 0,0);
    add(1,1,2, 0,0,0, 1,0,0, 1,0);
    add(1,1,3, 0,0,0, 1,0,0, 2,0);
    add(1,1,4, 0,0,0, 1,0,0, 3,0);
    add(1,1,5, 0,0,0, 0,0,0, 4,0);
    add(1,0,0, 1,1,0, 0,0,0, 4,0);
    add(1,0,0, 0,0,0, 0,1,1, 4,0);
    add(1,0,0, 1,2,1, 1,0,0, 3,0);
    add(1,0,0, 1,3,1, 1,0,0, 3,0);
    add(1,0,0, 1,4,1, 1,0,0, 2,0);
    add(1,0,0, 0,0,0, 1,0,0, 1,0);
    add(1,0,0, 0,0,0, 1,0,0, 0,0);
    add(1,1,5, 0,0,0, 1,0,0, 0,0);
    add(1,1,6, 0,0,0, 1,0,0, 1,0);
    add(1,0,0, 1,5,1, 1,0,0, 2,0);
    add(1,0,0, 1,6,0, 1,0,0, 2,0);
    add(1,0,0, 0,0,0, 1,1,6, 1,0);
    add(1,0,0, 0,0,0, 1,0,0, 0,0);
    add(1,0,0, 1,9,0, 1,0,0, 0,0);
    add(1,0,0, 0,0,0, 1,0,0, 0,1);
    add(1,0,0, 0,0,0, 1,0,0, 0,0);
    add(1,1,10, 1,10,0, 1,0,0, 0,0);
    add(1,0,0, 0,0,0, 1,1,10, 1,0);
    add(1,0,0, 0,0,0, 1,0,0, 0,0);

    rst = 0; dispatch_ready = 1;
    idle_inputs();
    @(posedge ck);
    model_update();
    #1;

    foreach (tbl[k]) begin
      rst          = tbl[k].r;
      issue_valid  = tbl[k].iv;
      issue_id     = tbl[k].iid;
      issue_instr  = {28'hA00_0000, tbl[k].iid};
      commit_valid = tbl[k].cv;
      commit_id    = tbl[k].cid;
      commit_kill  = tbl[k].kl;
      #1;
      chk($sformatf("v%0d_issue_ready", k), issue_ready, tbl[k].e_ir);
      chk($sformatf("v%0d_dispatch_valid", k), dispatch_valid, tbl[k].e_dv);
      chk($sformatf("v%0d_occupancy", k), occupancy, tbl[k].e_occ);
      chk($sformatf("v%0d_commit_miss", k), commit_miss, tbl[k].e_miss);
      if (tbl[k].e_dv) chk($sformatf("v%0d_dispatch_id", k), dispatch_id, tbl[k].e_did);
      cyc();
    end

    // Uncommitted head blocks a younger committed entry.
    idle_inputs();
    issue_valid = 1; issue_id = 7; issue_instr = 32'h7; cyc();
    issue_id = 8; issue_instr = 32'h8; cyc();
    idle_inputs();
    commit_valid = 1; commit_id = 8; cyc();
    idle_inputs();
    for (int i = 0; i < 20; i++) begin
      #1 chk("blocked_dispatch_valid", dispatch_valid, 0);
      cyc();
    end
    commit_valid = 1; commit_id = 7; cyc();
    idle_inputs();
    #1 chk("inorder_first", {dispatch_valid, dispatch_id}, {1'b1, 4'd7});
    cyc();
    #1 chk("inorder_second", {dispatch_valid, dispatch_id}, {1'b1, 4'd8});
    cyc();
    #1 chk("inorder_empty", occupancy, 0);

    // Stalled committed head, then reset mid-operation with traffic on the inputs.
    dispatch_ready = 0;
    issue_valid = 1; issue_id = 11; issue_instr = 32'hB;
    commit_valid = 1; commit_id = 11; cyc();
    idle_inputs();
    #1 chk("stall_offer", {dispatch_valid, dispatch_id}, {1'b1, 4'd11});
    cyc();
    #1 chk("stall_hold", {dispatch_valid, dispatch_id, dispatch_instr}, {1'b1, 4'd11, 32'hB});
    rst = 0; issue_valid = 1; issue_id = 12; commit_valid = 1; commit_id = 12;
    cyc();
    #1 chk("in_reset", {issue_ready, dispatch_valid, occupancy}, {1'b0, 1'b0, 3'd0});
    rst = 1; idle_inputs();
    cyc();
    #1 chk("post_reset", {dispatch_valid, occupancy}, {1'b0, 3'd0});
    dispatch_ready = 1;

    // Random traffic against the model; IDs drawn narrow so duplicates occur.
    for (int n = 0; n < 1500; n++) begin
      rst            = ($urandom_range(199) != 0);
      issue_valid    = $urandom_range(1);
      issue_id       = 4'($urandom_range(7));
      issue_instr    = $urandom;
      commit_valid   = $urandom_range(1);
      if (mq.size() > 0 && $urandom_range(3) != 0)
        commit_id = mq[$urandom_range(mq.size() - 1)].id;
      else
        commit_id = 4'($urandom_range(15));
      commit_kill    = ($urandom_range(3) == 0);
      dispatch_ready = ($urandom_range(3) != 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/commit_scheduler.md
COMMIT_SCHEDULER -- requirements
Module: commit_scheduler

Parameters
REQ-001 X_ID_WIDTH, 4, width of eXtension-interface instruction ID.
REQ-002 QUEUE_DEPTH, 4, speculative entries held (power of two, >=2).
REQ-003 INSTR_WIDTH, 32, width of stored instruction word.

Interface
REQ-004 ck  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-low reset.
REQ-006 issue_valid  in  1  offloaded instruction presented.
REQ-007 issue_ready  out  1  scheduler can accept an issue.
REQ-008 issue_id  in  X_ID_WIDTH  ID of issued instruction.
REQ-009 issue_instr  in  INSTR_WIDTH  issued instruction word.
REQ-010 commit_valid  in  1  commit transaction present (no ready).
REQ-011 commit_id  in  X_ID_WIDTH  ID being committed or killed.
REQ-012 commit_kill  in  1  1 = discard instruction, 0 = commit.
REQ-013 dispatch_valid  out  1  committed instruction offered to FPU pipeline.
REQ-014 dispatch_ready  in  1  FPU pipeline accepts (fpu_ready).
REQ-015 dispatch_id  out  X_ID_WIDTH  ID of offered instruction.
REQ-016 dispatch_instr  out  INSTR_WIDTH  offered instruction word.
REQ-017 occupancy  out  $clog2(QUEUE_DEPTH)+1  valid entries held.
REQ-018 commit_miss  out  1  registered one-cycle pulse: commit matched no entry.

Function
REQ-019 Storage: circular buffer of QUEUE_DEPTH entries {valid, committed, killed, id, instr}; head/tail pointers wrap modulo QUEUE_DEPTH.
REQ-020 issue_ready = rst & (occupancy != QUEUE_DEPTH); no pop-to-push bypass when full.
REQ-021 Issue accepted when issue_valid & issue_ready: entry written at tail {valid=1, committed=0, killed=0}, tail advances.
REQ-022 Commit match: lookup over valid, not-committed, not-killed entries; oldest (nearest head) match wins.
REQ-023 Commit with commit_kill=0 sets committed; with commit_kill=1 sets killed.
REQ-024 Commit in the same cycle as an accepted issue with equal ID, and no older match, applies to the new entry as written.
REQ-025 Commit with no match: state unchanged, commit_miss=1 next cycle.
REQ-026 dispatch_valid = head valid & committed & !killed; dispatch_id/instr driven from head entry, combinational from registered state.
REQ-027 Head popped on dispatch_valid & dispatch_ready; dispatch outputs stable while dispatch_valid & !dispatch_ready.
REQ-028 Head valid & killed: entry dropped in one cycle without dispatch_valid; one drop per cycle.
REQ-029 Head valid & not committed: head blocks; younger committed entries wait (in-order dispatch).
REQ-030 Issue and pop/drop in same cycle: occupancy unchanged, both pointers advance.
REQ-031 Dispatch latency: commit at edge N -> dispatch_valid high after edge N when entry at head.
REQ-032 occupancy ranges 0..QUEUE_DEPTH; increments on accepted issue, decrements on pop or drop.

Reset
REQ-033 rst=0 at a rising edge: all entry valid/committed/killed cleared, head=tail=0, occupancy=0, commit_miss=0, dispatch_valid=0.
REQ-034 issue_ready=0 while rst=0; issue and commit inputs ignored during reset.
REQ-035 Reset mid-operation discards all entries, including committed ones not yet dispatched; no dispatch_valid in the first cycle after release.

Verification
REQ-036 Issue IDs 1,2,3; commit 1,2,3; dispatch_ready=1 -> dispatch IDs 1,2,3 in order on consecutive cycles, occupancy 3->0.
REQ-037 Issue 4 IDs (depth 4) -> issue_ready=0 and a 5th issue is not accepted; one dispatch -> issue_ready=1 next cycle.
REQ-038 Issue IDs 5,6; kill 5, commit 6 -> 5 dropped without dispatch_valid, then 6 dispatched; occupancy 2->1->0.
REQ-039 Issue 7,8; commit 8 only -> no dispatch_valid for 20 cycles; commit 7 -> dispatch 7 then 8.
REQ-040 Commit ID 9 with empty buffer -> commit_miss=1 for exactly one cycle, occupancy stays 0.
REQ-041 Hold dispatch_ready=0 with committed head, pulse rst=0 -> outputs cleared; after release occupancy=0 and dispatch_valid=0.
